// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side adapter for the asynchronous FIFO, in the read clock domain. It turns
// the FIFO's r_en / empty / registered data_out handshake (data arrives one cycle
// after r_en) into a valid/ready stream master. A small circular prefetch buffer
// lets the consumer see one word per cycle with no bubbles, and the consumer
// never drives the FIFO itself.
//
// Parameters
//   DATA_WIDTH  width of FIFO data and stream payload
//   BUF_DEPTH   local prefetch entries (2..8); 3 or more gives full throughput
//
// Ports
//   rclk        read-domain clock, all logic on the rising edge
//   rrst        asynchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO data_out, valid the cycle after fifo_r_en was high
//   fifo_r_en   FIFO read enable
//   m_valid     stream data valid
//   m_ready     stream consumer ready
//   m_data      stream payload, held stable while m_valid && !m_ready
//   buf_count   words currently held in the buffer (in-flight read excluded)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                             rclk,
  input  logic                             rrst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic                             fifo_r_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  inflight;

  logic                  pop;
  logic [CNT_W:0]        committed;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits count the word already requested but not yet captured, so the
  // capture one cycle later always has a free slot. There is deliberately no
  // path from m_ready: a slot freed by a pop is only reused next cycle.
  assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fifo_r_en = !fifo_empty && (committed < DEPTH_EXT);

  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  // Buffer RAM is never reset, so the payload is forced to zero while idle.
  assign m_data    = m_valid ? mem[rd_ptr] : '0;
  assign buf_count = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (inflight) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      // Capture and pop together leave the occupancy unchanged.
      case ({inflight, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; only the pointers and count define what is
  // valid, so clearing the RAM would buy nothing.
  always_ff @(posedge rclk) begin
    if (inflight) mem[wr_ptr] <= fifo_rdata;
  end

endmodule
